// File: rtl/wowi_swap_sched_if.sv
// rtl/wowi_swap_sched_if.sv - requester and adapter bundles for the swap scheduler
// Requester side carries two packed lanes; adapter side is the word-wide BRAM adapter handshake.

interface wowi_swap_req_if;
   logic [1:0]  req_valid;
   logic [15:0] req_addr_a;
   logic [15:0] req_addr_b;
   logic [1:0]  req_done;
   logic [1:0]  req_err;

   modport master (
      output req_valid,
      output req_addr_a,
      output req_addr_b,
      input  req_done,
      input  req_err
   );

   modport slave (
      input  req_valid,
      input  req_addr_a,
      input  req_addr_b,
      output req_done,
      output req_err
   );
endinterface

interface wowi_swap_ad_if #(
   parameter int W = 16
);
   logic         ad_st_read;
   logic         ad_st_write;
   logic [7:0]   ad_base_addr;
   logic [W-1:0] ad_write_data;
   logic [W-1:0] ad_read_data;
   logic         ad_flip_ready;
   logic         ad_wrt_done;

   modport master (
      output ad_st_read,
      output ad_st_write,
      output ad_base_addr,
      output ad_write_data,
      input  ad_read_data,
      input  ad_flip_ready,
      input  ad_wrt_done
   );

   modport slave (
      input  ad_st_read,
      input  ad_st_write,
      input  ad_base_addr,
      input  ad_write_data,
      output ad_read_data,
      output ad_flip_ready,
      output ad_wrt_done
   );
endinterface

// File: rtl/wowi_swap_sched.sv
// rtl/wowi_swap_sched.sv - round-robin scheduler issuing atomic two-word swaps through one BRAM adapter
// Outputs are decoded from registered state, so an asynchronous reset clears them immediately.

module wowi_swap_sched #(
   parameter int DATA_WIDTH = 8,
   parameter int WORD_BYTES = 2,
   parameter int TIMEOUT    = 15
) (
   input  logic           clk,
   input  logic           rst,
   output logic           busy,
   wowi_swap_req_if.slave req,
   wowi_swap_ad_if.master ad
);

   localparam int W   = DATA_WIDTH * WORD_BYTES;
   localparam int WDW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_GRANT,
      S_RD_A,
      S_W_RA,
      S_RD_B,
      S_W_RB,
      S_WR_A,
      S_W_WA,
      S_WR_B,
      S_W_WB,
      S_FIN,
      S_ABORT
   } state_t;

   state_t         state_q, state_d;
   logic           gnt_q, gnt_d;
   logic           prio_q, prio_d;
   logic [7:0]     addr_a_q, addr_a_d;
   logic [7:0]     addr_b_q, addr_b_d;
   logic [W-1:0]   word_a_q, word_a_d;
   logic [W-1:0]   word_b_q, word_b_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic           wd_last;
   logic           pick;

   // The cycle with wd_q == TIMEOUT-1 is the last one a response is still honoured in.
   assign wd_last = (wd_q == WDW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         gnt_q    <= 1'b0;
         prio_q   <= 1'b0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         word_a_q <= '0;
         word_b_q <= '0;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         prio_q   <= prio_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         word_a_q <= word_a_d;
         word_b_q <= word_b_d;
         wd_q     <= wd_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      prio_d   = prio_q;
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
      word_a_d = word_a_q;
      word_b_d = word_b_q;
      wd_d     = wd_q;
      pick     = prio_q;

      case (state_q)
         S_IDLE: begin
            if (|req.req_valid) begin
               state_d = S_GRANT;
            end
         end

         S_GRANT: begin
            // prio_q names the requester that wins a tie; it flips away from each grant.
            if (req.req_valid == 2'b11) begin
               pick = prio_q;
            end else begin
               pick = req.req_valid[1];
            end
            if (|req.req_valid) begin
               gnt_d    = pick;
               prio_d   = ~pick;
               addr_a_d = pick ? req.req_addr_a[15:8] : req.req_addr_a[7:0];
               addr_b_d = pick ? req.req_addr_b[15:8] : req.req_addr_b[7:0];
               state_d  = (addr_a_d == addr_b_d) ? S_FIN : S_RD_A;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RD_A: begin
            wd_d    = '0;
            state_d = S_W_RA;
         end

         S_W_RA: begin
            if (ad.ad_flip_ready) begin
               word_a_d = ad.ad_read_data;
               state_d  = S_RD_B;
            end else if (wd_last) begin
               state_d = S_ABORT;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end

         S_RD_B: begin
            wd_d    = '0;
            state_d = S_W_RB;
         end

         S_W_RB: begin
            if (ad.ad_flip_ready) begin
               word_b_d = ad.ad_read_data;
               state_d  = S_WR_A;
            end else if (wd_last) begin
               state_d = S_ABORT;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end

         S_WR_A: begin
            wd_d    = '0;
            state_d = S_W_WA;
         end

         S_W_WA: begin
            if (ad.ad_wrt_done) begin
               state_d = S_WR_B;
            end else if (wd_last) begin
               state_d = S_ABORT;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end

         S_WR_B: begin
            wd_d    = '0;
            state_d = S_W_WB;
         end

         S_W_WB: begin
            if (ad.ad_wrt_done) begin
               state_d = S_FIN;
            end else if (wd_last) begin
               state_d = S_ABORT;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end

         S_FIN:   state_d = S_IDLE;
         S_ABORT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Address and data stay put from the start pulse through the matching wait state.
   always_comb begin
      busy             = (state_q != S_IDLE);
      ad.ad_st_read    = (state_q == S_RD_A) || (state_q == S_RD_B);
      ad.ad_st_write   = (state_q == S_WR_A) || (state_q == S_WR_B);
      ad.ad_base_addr  = '0;
      ad.ad_write_data = '0;
      req.req_done     = 2'b00;
      req.req_err      = 2'b00;

      case (state_q)
         S_RD_A, S_W_RA: ad.ad_base_addr = addr_a_q;
         S_RD_B, S_W_RB: ad.ad_base_addr = addr_b_q;
         S_WR_A, S_W_WA: begin
            ad.ad_base_addr  = addr_a_q;
            ad.ad_write_data = word_b_q;
         end
         S_WR_B, S_W_WB: begin
            ad.ad_base_addr  = addr_b_q;
            ad.ad_write_data = word_a_q;
         end
         S_FIN:   req.req_done = gnt_q ? 2'b10 : 2'b01;
         S_ABORT: req.req_err  = gnt_q ? 2'b10 : 2'b01;
         default: ;
      endcase
   end

endmodule
